jogador_automatico: RTL and testbench

Automatic player for `jogo_desafio_memoria`: drives the game's `jogar`/`botoes` inputs and watches its `leds`/`ganhou`/`perdeu` outputs. It starts a game, records each sequence the game shows on the LEDs, and replays that sequence as timed button presses, round after round, until the game reports win or loss. It sits beside the game in board-level self-test builds and in regression benches, where it replaces hand-written stimulus.

---
 rtl/jogador_automatico.sv | 183 ++++++++++++++++++
 tb/tb_jogador_automatico.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/jogador_automatico.sv
// jogador_automatico: watches jogo_desafio_memoria, records each shown sequence and replays it.
// Define JOGADOR_ERRO_EN to corrupt the press at ERR_POS of every long enough round.
module jogador_automatico #(
   parameter int DEPTH          = 16,
   parameter int START_CYCLES   = 5,
   parameter int PRESS_CYCLES   = 10,
   parameter int GAP_CYCLES     = 10,
   parameter int SILENCE_CYCLES = 2000,
   parameter int ERR_POS        = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic [3:0] leds,
   input  logic       ganhou,
   input  logic       perdeu,
   output logic       jogar,
   output logic [3:0] botoes,
   output logic       ocupado,
   output logic [3:0] rodada,
   output logic       venceu,
   output logic       falhou,
   output logic       erro
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int M1 = (START_CYCLES > PRESS_CYCLES) ? START_CYCLES : PRESS_CYCLES;
   localparam int M2 = (GAP_CYCLES > SILENCE_CYCLES) ? GAP_CYCLES : SILENCE_CYCLES;
   localparam int ML = (M1 > M2) ? M1 : M2;
   localparam int TW = (ML > 1) ? $clog2(ML) : 1;

   typedef enum logic [2:0] {
      OCIOSO, INICIA, OBSERVA, ACESO,
      SILENCIO, PRESSIONA, INTERVALO, FIM
   } estado_t;

   estado_t       state, state_n;
   logic [TW-1:0] tmr, tmr_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [IW-1:0] idx, idx_n;
   logic [3:0]    mem [DEPTH];
   logic          wr_en;
   logic          venceu_n, falhou_n, erro_n;
   logic [3:0]    rodada_n;
   logic          jogar_n, ocupado_n;
   logic [3:0]    botoes_n, press;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= OCIOSO;
         tmr     <= '0;
         cnt     <= '0;
         idx     <= '0;
         rodada  <= '0;
         venceu  <= 1'b0;
         falhou  <= 1'b0;
         erro    <= 1'b0;
         jogar   <= 1'b0;
         ocupado <= 1'b0;
         botoes  <= '0;
      end else begin
         state   <= state_n;
         tmr     <= tmr_n;
         cnt     <= cnt_n;
         idx     <= idx_n;
         rodada  <= rodada_n;
         venceu  <= venceu_n;
         falhou  <= falhou_n;
         erro    <= erro_n;
         jogar   <= jogar_n;
         ocupado <= ocupado_n;
         botoes  <= botoes_n;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) mem[cnt[IW-1:0]] <= leds;
   end

   always_comb begin
      state_n  = state;
      tmr_n    = tmr;
      cnt_n    = cnt;
      idx_n    = idx;
      wr_en    = 1'b0;
      venceu_n = venceu;
      falhou_n = falhou;
      erro_n   = erro;
      rodada_n = rodada;
      unique case (state)
         OCIOSO, FIM: begin
            if (iniciar) begin
               venceu_n = 1'b0;
               falhou_n = 1'b0;
               erro_n   = 1'b0;
               rodada_n = '0;
               cnt_n    = '0;
               tmr_n    = '0;
               state_n  = INICIA;
            end
         end
         INICIA: begin
            if (tmr == TW'(START_CYCLES - 1)) begin
               tmr_n   = '0;
               state_n = OBSERVA;
            end else begin
               tmr_n = tmr + 1'b1;
            end
         end
         OBSERVA, SILENCIO: begin
            if (leds != 4'b0) begin
               if (!$onehot(leds) || cnt == CW'(DEPTH)) begin
                  erro_n  = 1'b1;
                  state_n = FIM;
               end else begin
                  wr_en   = 1'b1;
                  cnt_n   = cnt + 1'b1;
                  state_n = ACESO;
               end
            end else if (state == SILENCIO) begin
               if (tmr == TW'(SILENCE_CYCLES - 1)) begin
                  rodada_n = 4'(cnt);
                  idx_n    = '0;
                  tmr_n    = '0;
                  state_n  = PRESSIONA;
               end else begin
                  tmr_n = tmr + 1'b1;
               end
            end
         end
         // a value change without a return to zero is the same element
         ACESO: begin
            if (leds == 4'b0) begin
               tmr_n   = '0;
               state_n = SILENCIO;
            end
         end
         PRESSIONA: begin
            if (tmr == TW'(PRESS_CYCLES - 1)) begin
               tmr_n   = '0;
               state_n = INTERVALO;
            end else begin
               tmr_n = tmr + 1'b1;
            end
         end
         INTERVALO: begin
            if (tmr == TW'(GAP_CYCLES - 1)) begin
               tmr_n = '0;
               if (CW'(idx) + 1'b1 < cnt) begin
                  idx_n   = idx + 1'b1;
                  state_n = PRESSIONA;
               end else begin
                  cnt_n   = '0;
                  state_n = OBSERVA;
               end
            end else begin
               tmr_n = tmr + 1'b1;
            end
         end
         default: state_n = OCIOSO;
      endcase
      if (state != OCIOSO && state != FIM && (ganhou || perdeu)) begin
         venceu_n = venceu | ganhou;
         falhou_n = falhou | perdeu;
         wr_en    = 1'b0;
         state_n  = FIM;
      end
   end

   // outputs are computed from the next state so they register in step with it
   always_comb begin
      press = mem[idx_n];
`ifdef JOGADOR_ERRO_EN
      if (CW'(idx_n) == CW'(ERR_POS) && cnt_n > CW'(ERR_POS))
         press = {press[2:0], press[3]};
`endif
      jogar_n   = (state_n == INICIA);
      ocupado_n = (state_n != OCIOSO) && (state_n != FIM);
      botoes_n  = (state_n == PRESSIONA) ? press : 4'b0;
   end

endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: a behavioural game drives leds, a scoreboard
// monitor checks every replayed press against expectations queued by the game.
module tb_jogador_automatico;

   localparam int S   = 2000;
   localparam int P   = 10;
   localparam int G   = 10;
   localparam int ERR = 3;
`ifdef JOGADOR_ERRO_EN
   localparam int NR  = 4;
`else
   localparam int NR  = 8;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       iniciar = 1'b0;
   logic       ganhou = 1'b0;
   logic       perdeu = 1'b0;
   logic [3:0] leds = 4'b0;
   logic       jogar, ocupado, venceu, falhou, erro;
   logic [3:0] botoes, rodada;

   int cyc = 0;
   int n_chk = 0;
   int n_err = 0;
   int releases = 0;
   bit sb_on = 1'b1;

   typedef struct {
      logic [3:0] val;
      int         start;
   } exp_t;
   exp_t exp_q[$];

   logic [3:0] seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                           4'b0100, 4'b0010, 4'b0001, 4'b0001};

   jogador_automatico dut (
      .clock   (clk),
      .reset   (rst_n),
      .iniciar (iniciar),
      .leds    (leds),
      .ganhou  (ganhou),
      .perdeu  (perdeu),
      .jogar   (jogar),
      .botoes  (botoes),
      .ocupado (ocupado),
      .rodada  (rodada),
      .venceu  (venceu),
      .falhou  (falhou),
      .erro    (erro)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // scoreboard monitor
   initial begin
      bit         in_press;
      int         p_start;
      logic [3:0] p_val;
      exp_t       e;
      in_press = 1'b0;
      p_start  = 0;
      forever begin
         @(negedge clk);
         if (!sb_on) begin
            in_press = 1'b0;
         end else if (!in_press && botoes != 4'b0) begin
            in_press = 1'b1;
            p_start  = cyc;
            p_val    = botoes;
            if (exp_q.size() == 0) begin
               chk("press_unexpected", int'(p_val), 0);
            end else begin
               e = exp_q.pop_front();
               chk("press_val", int'(p_val), int'(e.val));
               chk("press_start", p_start, e.start);
            end
         end else if (in_press && botoes == 4'b0) begin
            in_press = 1'b0;
            releases++;
            chk("press_len", cyc - p_start, P);
         end
      end
   end

   task automatic start_game();
      int w = 0;
      iniciar = 1'b1;
      @(posedge clk); #1 iniciar = 1'b0;
      chk("jogar_rise", int'(jogar), 1);
      chk("ocupado_start", int'(ocupado), 1);
      while (jogar && w < 50) begin
         w++;
         @(posedge clk); #1;
      end
      chk("jogar_len", w, 5);
   endtask

   task automatic play_round(input int n, input bit push);
      int f = 0;
      int base;
      int budget;
      logic [3:0] v;
      base = releases;
      for (int k = 0; k < n; k++) begin
         leds = seq[k];
         repeat (10) @(posedge clk);
         #1 leds = 4'b0;
         f = cyc;
         repeat (5) @(posedge clk);
         #1;
      end
      if (push) begin
         for (int k = 0; k < n; k++) begin
            v = seq[k];
`ifdef JOGADOR_ERRO_EN
            if (n > ERR && k == ERR) v = {v[2:0], v[3]};
`endif
            exp_q.push_back('{v, f + S + 1 + k * (P + G)});
         end
         budget = S + n * (P + G) + 100;
         while (releases < base + n && budget > 0) begin
            @(posedge clk); #1;
            budget--;
         end
         chk("round_replayed", releases - base, n);
         repeat (20) @(posedge clk);
         #1;
         chk("rodada", int'(rodada), n);
      end
   endtask

   initial begin
      int w;
      #2 chk("reset_outputs",
             int'({jogar, ocupado, venceu, falhou, erro, rodada, botoes}), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      start_game();
      play_round(1, 1'b1);

      // asynchronous reset in the middle of a press
      sb_on = 1'b0;
      play_round(2, 1'b0);
      w = 0;
      while (botoes == 4'b0 && w < S + 100) begin
         @(posedge clk); #1;
         w++;
      end
      chk("press_seen", int'(botoes != 4'b0), 1);
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk("async_reset", int'({jogar, ocupado, botoes}), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("idle_after_reset", int'({jogar, ocupado, botoes}), 0);
      sb_on = 1'b1;

      // full game
      start_game();
      for (int r = 1; r <= NR; r++) play_round(r, 1'b1);
`ifdef JOGADOR_ERRO_EN
      perdeu = 1'b1;
      @(posedge clk); #1 perdeu = 1'b0;
      chk("falhou", int'(falhou), 1);
      chk("venceu_lost", int'(venceu), 0);
`else
      ganhou = 1'b1;
      @(posedge clk); #1 ganhou = 1'b0;
      chk("venceu", int'(venceu), 1);
      chk("falhou_won", int'(falhou), 0);
`endif
      chk("rodada_final", int'(rodada), NR);
      chk("ocupado_fim", int'(ocupado), 0);
      chk("erro_clean", int'(erro), 0);

      // non one-hot LED value, restarting from FIM
      start_game();
      chk("restart_clears", int'({venceu, falhou}), 0);
      leds = 4'b0011;
      @(posedge clk); #1 leds = 4'b0;
      chk("erro_onehot", int'(erro), 1);
      chk("ocupado_onehot", int'(ocupado), 0);

      // overflow: 17 elements into a 16-deep store
      start_game();
      chk("erro_cleared", int'(erro), 0);
      for (int k = 0; k < 17; k++) begin
         leds = 4'(1 << (k % 4));
         repeat (3) @(posedge clk);
         #1 leds = 4'b0;
         if (k == 15) chk("erro_at_depth", int'(erro), 0);
         repeat (3) @(posedge clk);
         #1;
      end
      chk("erro_overflow", int'(erro), 1);
      chk("ocupado_overflow", int'(ocupado), 0);
      chk("rodada_overflow", int'(rodada), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: bench did not complete, %0d checks so far", n_chk);
      $fatal(1);
   end

endmodule
